ccff_chain_loader: RTL

//  Configuration-chain loader and memory bank driving the sel/selb pins of the TGATE-based routing/LUT muxes.

---
 rtl/ccff_chain_loader_if.sv | 13 +
 rtl/ccff_chain_loader.sv | 124 ++++++++++++
 2 files changed

// File: rtl/ccff_chain_loader_if.sv
// Bitstream word handshake between a configuration source and ccff_chain_loader.
// cfg_start restarts a load; cfg_data moves on cfg_valid & cfg_ready.
interface ccff_chain_loader_if #(
    parameter int unsigned WORD_W = 8
);
    logic              cfg_start;
    logic [WORD_W-1:0] cfg_data;
    logic              cfg_valid;
    logic              cfg_ready;

    modport master (output cfg_start, output cfg_data, output cfg_valid, input cfg_ready);
    modport slave  (input cfg_start, input cfg_data, input cfg_valid, output cfg_ready);
endinterface

// File: rtl/ccff_chain_loader.sv
// Configuration-chain loader: serializes bitstream words LSB-first into a shift chain
// and commits the full chain to a double-buffered sel/selb bank for TGATE muxes.
module ccff_chain_loader #(
    parameter int unsigned WORD_W    = 8,
    parameter int unsigned CHAIN_LEN = 32
) (
    input  logic                 prog_clk,
    input  logic                 pReset,
    ccff_chain_loader_if.slave   cfg,
    output logic                 busy,
    output logic                 cfg_done,
    output logic                 ccff_tail,
    output logic [CHAIN_LEN-1:0] mem_out,
    output logic [CHAIN_LEN-1:0] mem_outb
);
    localparam int unsigned NUM_WORDS = CHAIN_LEN / WORD_W;
    localparam int unsigned BIT_W     = (WORD_W > 1) ? $clog2(WORD_W) : 1;
    localparam int unsigned CNT_W     = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;

    typedef enum logic [2:0] {IDLE, LOAD, SHIFT, COMMIT, DONE} state_t;

    state_t               state, state_next;
    logic [CHAIN_LEN-1:0] shift_reg;
    logic [WORD_W-1:0]    hold;
    logic [BIT_W-1:0]     bit_cnt;
    logic [CNT_W-1:0]     word_cnt;
    logic                 do_clear, do_accept, do_shift, do_commit;
    logic                 last_bit, last_word;

    assign last_bit  = (bit_cnt == BIT_W'(WORD_W - 1));
    assign last_word = (word_cnt == CNT_W'(NUM_WORDS - 1));
    assign ccff_tail = shift_reg[CHAIN_LEN-1];

    // Next-state and datapath strobes; a restart always beats a word transfer.
    always_comb begin
        state_next = state;
        do_clear   = 1'b0;
        do_accept  = 1'b0;
        do_shift   = 1'b0;
        do_commit  = 1'b0;
        case (state)
            IDLE: begin
                if (cfg.cfg_start) begin
                    do_clear   = 1'b1;
                    state_next = LOAD;
                end
            end
            LOAD: begin
                if (cfg.cfg_start) begin
                    do_clear = 1'b1;
                end else if (cfg.cfg_valid) begin
                    do_accept  = 1'b1;
                    state_next = SHIFT;
                end
            end
            SHIFT: begin
                if (cfg.cfg_start) begin
                    do_clear   = 1'b1;
                    state_next = LOAD;
                end else begin
                    do_shift = 1'b1;
                    if (last_bit) begin
                        state_next = last_word ? COMMIT : LOAD;
                    end
                end
            end
            COMMIT: begin
                do_commit  = 1'b1;
                state_next = DONE;
            end
            DONE: begin
                if (cfg.cfg_start) begin
                    do_clear   = 1'b1;
                    state_next = LOAD;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // State, chain, counters and the committed bank.
    always_ff @(posedge prog_clk) begin
        if (pReset) begin
            state         <= IDLE;
            shift_reg     <= '0;
            hold          <= '0;
            bit_cnt       <= '0;
            word_cnt      <= '0;
            mem_out       <= '0;
            mem_outb      <= '1;
            cfg.cfg_ready <= 1'b0;
            busy          <= 1'b0;
            cfg_done      <= 1'b0;
        end else begin
            state         <= state_next;
            cfg.cfg_ready <= (state_next == LOAD);
            busy          <= (state_next == LOAD) || (state_next == SHIFT) || (state_next == COMMIT);
            cfg_done      <= (state_next == DONE);
            if (do_clear) begin
                shift_reg <= '0;
                bit_cnt   <= '0;
                word_cnt  <= '0;
            end
            if (do_accept) begin
                hold    <= cfg.cfg_data;
                bit_cnt <= '0;
            end
            if (do_shift) begin
                shift_reg <= (shift_reg << 1) | CHAIN_LEN'(hold[bit_cnt]);
                if (last_bit) begin
                    bit_cnt  <= '0;
                    word_cnt <= word_cnt + CNT_W'(1);
                end else begin
                    bit_cnt <= bit_cnt + BIT_W'(1);
                end
            end
            // Bank only moves here, so pass-gates never see a partial pattern.
            if (do_commit) begin
                mem_out  <= shift_reg;
                mem_outb <= ~shift_reg;
            end
        end
    end
endmodule
